// File: rtl/i2c_write_sequencer.sv
// I2C write transaction sequencer.
// Buffers host data bytes in a FIFO, launches the controller with a start
// pulse, follows bus progress by watching SCL/SDA, and reports
// done / NACK / timeout back to the host.
module i2c_write_sequencer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic [6:0]                    i_cmd_addr,
  input  logic                          i_cmd_rw,
  input  logic [2:0]                    i_cmd_len,
  input  logic                          i_wr_valid,
  output logic                          o_wr_ready,
  input  logic [7:0]                    i_wr_data,
  input  logic                          i_scl,
  input  logic                          i_sda,
  output logic                          o_start,
  output logic [6:0]                    o_addr,
  output logic                          o_read_or_write,
  output logic [2:0]                    o_word_cnt,
  output logic [7:0]                    o_data_write,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_nack_err,
  output logic                          o_timeout_err,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_START, ADDR, DATA, WAIT_STOP, FLUSH, DONE
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]   level_nxt;
  logic [7:0]    head_nxt;
  logic          push, pop, pop_ok;

  logic scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_edge, start_det, stop_det;

  logic [3:0]    edge_cnt;
  logic          ack_sda;
  logic [2:0]    sent;
  logic [TW-1:0] tmo_cnt;
  logic          counting, tmo_hit, cmd_acc;
  logic          clr_edge, inc_sent, set_nack, set_tmo;

  assign o_wr_ready  = (o_fifo_level != (AW+1)'(FIFO_DEPTH));
  assign push        = i_wr_valid && o_wr_ready;
  assign pop_ok      = pop && (o_fifo_level != '0);
  assign o_cmd_ready = (state == IDLE) && (o_fifo_level >= (AW+1)'(i_cmd_len));
  assign cmd_acc     = i_cmd_valid && o_cmd_ready;
  assign o_busy      = (state != IDLE);

  // Bus line synchronizers plus one delay stage for edge detection; idle bus is high.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    // NOTE: every sequential block uses non-blocking assignments so all flops
    // see pre-edge values, which keeps the synchronizer chain a true shift.
    if (!i_nrst) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_d} <= {i_scl, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_d} <= {i_sda, sda_s1, sda_s2};
    end
  end

  assign scl_rise  = scl_s2 && !scl_d;
  assign scl_edge  = scl_s2 ^ scl_d;
  assign start_det = scl_s2 && scl_d && sda_d && !sda_s2;
  assign stop_det  = scl_s2 && scl_d && !sda_d && sda_s2;

  // FIFO storage write port.
  always_ff @(posedge i_clk) begin
    // NOTE: the data array carries no reset; the pointers and level alone
    // define which entries are valid, so clearing storage would only cost logic.
    if (push) mem[wr_ptr] <= i_wr_data;
  end

  // Next FIFO level, read pointer and head byte (bypass when the pushed byte becomes head).
  always_comb begin
    rd_ptr_nxt = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
    level_nxt  = o_fifo_level + (AW+1)'(push) - (AW+1)'(pop_ok);
    if (level_nxt == '0)                 head_nxt = 8'h00;
    else if (push && rd_ptr_nxt == wr_ptr) head_nxt = i_wr_data;
    else                                 head_nxt = mem[rd_ptr_nxt];
  end

  // FIFO pointers, level and registered head byte.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fifo_level <= '0;
      o_data_write <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr       <= rd_ptr_nxt;
      o_fifo_level <= level_nxt;
      o_data_write <= head_nxt;
    end
  end

  assign counting = (state == WAIT_START) || (state == ADDR) ||
                    (state == DATA) || (state == WAIT_STOP);
  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYCLES));

  // State register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state, pop control and pulse outputs; a timeout overrides all bus progress.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_nxt = state;
    pop       = 1'b0;
    clr_edge  = 1'b0;
    inc_sent  = 1'b0;
    set_nack  = 1'b0;
    set_tmo   = 1'b0;
    o_start   = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE:       if (cmd_acc) state_nxt = LAUNCH;
      LAUNCH: begin
        o_start   = 1'b1;
        state_nxt = WAIT_START;
      end
      WAIT_START: if (start_det) begin
        clr_edge  = 1'b1;
        state_nxt = ADDR;
      end
      ADDR: if (edge_cnt == 4'd9) begin
        if (ack_sda) begin
          set_nack  = 1'b1;
          state_nxt = WAIT_STOP;
        end else if (o_word_cnt == 3'd0) begin
          state_nxt = WAIT_STOP;
        end else begin
          clr_edge  = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: if (edge_cnt == 4'd9) begin
        pop      = 1'b1;
        inc_sent = 1'b1;
        if (ack_sda) begin
          set_nack  = 1'b1;
          state_nxt = WAIT_STOP;
        end else if (sent + 3'd1 == o_word_cnt) begin
          state_nxt = WAIT_STOP;
        end else begin
          clr_edge = 1'b1;
        end
      end
      WAIT_STOP:  if (stop_det) state_nxt = FLUSH;
      FLUSH: begin
        if (sent == o_word_cnt) begin
          state_nxt = DONE;
        end else begin
          pop      = 1'b1;
          inc_sent = 1'b1;
        end
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default:    state_nxt = IDLE;
    endcase
    if (counting && tmo_hit) begin
      state_nxt = FLUSH;
      set_tmo   = 1'b1;
      pop       = 1'b0;
      inc_sent  = 1'b0;
      set_nack  = 1'b0;
      clr_edge  = 1'b0;
    end
  end

  // Latched command, sent counter and sticky error flags.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_addr          <= 7'h00;
      o_read_or_write <= 1'b0;
      o_word_cnt      <= 3'd0;
      sent            <= 3'd0;
      o_nack_err      <= 1'b0;
      o_timeout_err   <= 1'b0;
    end else begin
      if (cmd_acc) begin
        o_addr          <= i_cmd_addr;
        o_read_or_write <= i_cmd_rw;
        o_word_cnt      <= i_cmd_len;
        sent            <= 3'd0;
        o_nack_err      <= 1'b0;
        o_timeout_err   <= 1'b0;
      end
      if (inc_sent) sent <= sent + 3'd1;
      if (set_nack) o_nack_err <= 1'b1;
      if (set_tmo)  o_timeout_err <= 1'b1;
    end
  end

  // SCL rise counter (saturating at 9), ACK sample on the 9th rise, and bus-idle timer.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      edge_cnt <= 4'd0;
      ack_sda  <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      if (clr_edge)
        edge_cnt <= 4'd0;
      else if (scl_rise && (state == ADDR || state == DATA) && edge_cnt != 4'd9)
        edge_cnt <= edge_cnt + 4'd1;
      if (scl_rise && edge_cnt == 4'd8) ack_sda <= sda_s2;
      if (state == LAUNCH || scl_edge) tmo_cnt <= '0;
      else if (counting)               tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Directed testbench for i2c_write_sequencer: models the I2C bus by hand and
// checks FIFO behaviour, transaction flow, errors and reset.
module tb_i2c_write_sequencer;

  localparam int TIMEOUT_CYCLES = 4096;

  logic       i_clk = 1'b0;
  logic       i_nrst;
  logic       i_cmd_valid, i_cmd_rw, i_wr_valid, i_scl, i_sda;
  logic [6:0] i_cmd_addr;
  logic [2:0] i_cmd_len;
  logic [7:0] i_wr_data;
  logic       o_cmd_ready, o_wr_ready, o_start, o_read_or_write, o_busy, o_done;
  logic       o_nack_err, o_timeout_err;
  logic [6:0] o_addr;
  logic [2:0] o_word_cnt;
  logic [7:0] o_data_write;
  logic [3:0] o_fifo_level;

  int tests = 0;
  int fails = 0;
  int n_start = 0;
  int n_done = 0;
  int s0, d0, n;
  logic [7:0] pre_pop, post_pop;

  i2c_write_sequencer #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_addr(i_cmd_addr), .i_cmd_rw(i_cmd_rw), .i_cmd_len(i_cmd_len),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
    .i_scl(i_scl), .i_sda(i_sda),
    .o_start(o_start), .o_addr(o_addr), .o_read_or_write(o_read_or_write),
    .o_word_cnt(o_word_cnt), .o_data_write(o_data_write), .o_busy(o_busy),
    .o_done(o_done), .o_nack_err(o_nack_err), .o_timeout_err(o_timeout_err),
    .o_fifo_level(o_fifo_level)
  );

  always #5 i_clk = ~i_clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge i_clk) begin
    if (o_start) n_start++;
    if (o_done)  n_done++;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    i_wr_data  = d;
    i_wr_valid = 1'b1;
    tick();
    i_wr_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [6:0] a, input logic rw, input logic [2:0] len);
    int k;
    k = 0;
    i_cmd_addr  = a;
    i_cmd_rw    = rw;
    i_cmd_len   = len;
    i_cmd_valid = 1'b1;
    #1;
    while (!o_cmd_ready && k < 50) begin
      tick();
      k++;
    end
    check("cmd_ready_wait", 32'(k < 50), 32'd1);
    tick();
    i_cmd_valid = 1'b0;
  endtask

  // One SCL clock; records the head byte in the cycle of the post-9th-rise pop and after it.
  task automatic bus_bit(input logic b, input logic do_push, input logic [7:0] pd);
    i_sda = b;
    repeat (2) tick();
    i_scl = 1'b1;
    repeat (3) tick();
    pre_pop = o_data_write;
    if (do_push) begin
      i_wr_data  = pd;
      i_wr_valid = 1'b1;
    end
    tick();
    i_wr_valid = 1'b0;
    post_pop   = o_data_write;
    tick();
    i_scl = 1'b0;
    repeat (3) tick();
  endtask

  task automatic bus_byte(input logic [7:0] d, input logic ack, input logic do_push,
                          input logic [7:0] pd);
    for (int i = 7; i >= 0; i--) bus_bit(d[i], 1'b0, 8'h00);
    bus_bit(ack, do_push, pd);
  endtask

  task automatic bus_start();
    i_scl = 1'b1;
    i_sda = 1'b1;
    repeat (3) tick();
    i_sda = 1'b0;
    repeat (4) tick();
    i_scl = 1'b0;
    repeat (3) tick();
  endtask

  task automatic bus_stop();
    i_sda = 1'b0;
    repeat (2) tick();
    i_scl = 1'b1;
    repeat (4) tick();
    i_sda = 1'b1;
    tick();
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!o_done && k < 200) begin
      tick();
      k++;
    end
    check(tag, 32'(o_done), 32'd1);
    tick();
  endtask

  initial begin
    i_nrst = 1'b0; i_cmd_valid = 1'b0; i_cmd_rw = 1'b0; i_cmd_addr = 7'h00;
    i_cmd_len = 3'd1; i_wr_valid = 1'b0; i_wr_data = 8'h00; i_scl = 1'b1; i_sda = 1'b1;
    pre_pop = 8'h00; post_pop = 8'h00;
    repeat (3) tick();

    // Reset state
    check("rst_flags", 32'({o_start, o_busy, o_done, o_nack_err, o_timeout_err,
                            o_read_or_write, o_cmd_ready}), 32'd0);
    check("rst_regs", 32'({o_addr, o_word_cnt, o_data_write, o_fifo_level}), 32'd0);
    check("rst_wr_ready", 32'(o_wr_ready), 32'd1);
    i_nrst = 1'b1;
    tick();

    // Single-byte write
    push_byte(8'hA5);
    check("t1_level_push", 32'(o_fifo_level), 32'd1);
    check("t1_head", 32'(o_data_write), 32'hA5);
    s0 = n_start; d0 = n_done;
    send_cmd(7'h50, 1'b0, 3'd1);
    check("t1_start", 32'({o_start, o_busy}), 32'b11);
    check("t1_latched", 32'({o_addr, o_word_cnt}), 32'({7'h50, 3'd1}));
    bus_start();
    bus_byte(8'hA0, 1'b0, 1'b0, 8'h00);
    check("t1_no_pop_in_addr", 32'({o_fifo_level, o_data_write}), 32'({4'd1, 8'hA5}));
    bus_byte(8'hA5, 1'b0, 1'b0, 8'h00);
    check("t1_popped", 32'({o_fifo_level, o_data_write}), 32'd0);
    bus_stop();
    wait_done("t1_done");
    check("t1_start_cnt", 32'(n_start - s0), 32'd1);
    check("t1_done_cnt", 32'(n_done - d0), 32'd1);
    check("t1_idle_noerr", 32'({o_busy, o_nack_err, o_timeout_err}), 32'd0);

    // Address-only probe
    i_cmd_len = 3'd0;
    #1;
    check("t2_ready_empty", 32'(o_cmd_ready), 32'd1);
    d0 = n_done;
    send_cmd(7'h3C, 1'b0, 3'd0);
    check("t2_word_cnt", 32'({o_start, o_word_cnt}), 32'({1'b1, 3'd0}));
    bus_start();
    bus_byte(8'h78, 1'b0, 1'b0, 8'h00);
    bus_stop();
    wait_done("t2_done");
    check("t2_done_cnt", 32'(n_done - d0), 32'd1);
    check("t2_state", 32'({o_fifo_level, o_data_write, o_nack_err}), 32'd0);

    // Multi-byte write
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    check("t3_level", 32'(o_fifo_level), 32'd3);
    send_cmd(7'h2A, 1'b0, 3'd3);
    bus_start();
    bus_byte(8'h54, 1'b0, 1'b0, 8'h00);
    check("t3_head0", 32'(o_data_write), 32'h11);
    bus_byte(8'h11, 1'b0, 1'b0, 8'h00);
    check("t3_step1", 32'({pre_pop, post_pop, 4'(o_fifo_level)}), 32'({8'h11, 8'h22, 4'd2}));
    bus_byte(8'h22, 1'b0, 1'b0, 8'h00);
    check("t3_step2", 32'({pre_pop, post_pop, 4'(o_fifo_level)}), 32'({8'h22, 8'h33, 4'd1}));
    bus_byte(8'h33, 1'b0, 1'b0, 8'h00);
    check("t3_step3", 32'({pre_pop, post_pop, 4'(o_fifo_level)}), 32'({8'h33, 8'h00, 4'd0}));
    bus_stop();
    wait_done("t3_done");
    check("t3_noerr", 32'({o_nack_err, o_timeout_err}), 32'd0);

    // Address NACK with three queued bytes
    push_byte(8'h44);
    push_byte(8'h55);
    push_byte(8'h66);
    send_cmd(7'h21, 1'b0, 3'd3);
    bus_start();
    bus_byte(8'h42, 1'b1, 1'b0, 8'h00);
    check("t4_nack_set", 32'({o_nack_err, o_fifo_level}), 32'({1'b1, 4'd3}));
    bus_stop();
    n = 0;
    while (o_fifo_level == 4'd3 && n < 50) begin
      tick();
      n++;
    end
    check("t4_flush1", 32'(o_fifo_level), 32'd2);
    tick();
    check("t4_flush2", 32'(o_fifo_level), 32'd1);
    tick();
    check("t4_flush3", 32'({o_fifo_level, o_done}), 32'({4'd0, 1'b0}));
    tick();
    check("t4_done", 32'({o_done, o_nack_err}), 32'b11);
    tick();

    // Timeout: SCL held static after launch
    push_byte(8'h77);
    push_byte(8'h88);
    send_cmd(7'h33, 1'b1, 3'd2);
    check("t5_nack_cleared", 32'({o_nack_err, o_timeout_err, o_read_or_write}), 32'b001);
    n = 0;
    while (!o_timeout_err && n < 5000) begin
      tick();
      n++;
    end
    check("t5_tmo_window", 32'(n >= TIMEOUT_CYCLES && n <= TIMEOUT_CYCLES + 4), 32'd1);
    wait_done("t5_done");
    check("t5_flushed", 32'({o_fifo_level, o_busy, o_timeout_err}), 32'({4'd0, 1'b0, 1'b1}));

    // FIFO boundaries
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    check("t6_full", 32'({o_fifo_level, o_wr_ready, o_data_write}), 32'({4'd8, 1'b0, 8'h01}));
    i_wr_data  = 8'h99;
    i_wr_valid = 1'b1;
    repeat (3) tick();
    i_wr_valid = 1'b0;
    check("t6_ninth_dropped", 32'({o_fifo_level, o_data_write}), 32'({4'd8, 8'h01}));
    send_cmd(7'h10, 1'b0, 3'd3);
    bus_start();
    bus_byte(8'h20, 1'b0, 1'b0, 8'h00);
    bus_byte(8'h01, 1'b0, 1'b0, 8'h00);
    check("t6_pop_from_full", 32'({o_fifo_level, o_data_write}), 32'({4'd7, 8'h02}));
    bus_byte(8'h02, 1'b0, 1'b1, 8'hAB);
    check("t6_push_pop_same", 32'({o_fifo_level, pre_pop, post_pop}), 32'({4'd7, 8'h02, 8'h03}));
    // Reset in the middle of the third data byte
    i_sda = 1'b0;
    tick();
    i_scl = 1'b1;
    repeat (2) tick();
    i_nrst = 1'b0;
    #1;
    check("t6_rst_flags", 32'({o_start, o_busy, o_done, o_nack_err, o_timeout_err,
                               o_read_or_write, o_cmd_ready}), 32'd0);
    check("t6_rst_regs", 32'({o_addr, o_word_cnt, o_data_write, o_fifo_level}), 32'd0);
    check("t6_rst_wr_ready", 32'(o_wr_ready), 32'd1);
    i_scl = 1'b0;
    tick();
    i_nrst = 1'b1;
    i_scl  = 1'b1;
    i_sda  = 1'b1;
    s0 = n_start;
    repeat (10) tick();
    check("t6_no_restart", 32'({n_start - s0}), 32'd0);
    check("t6_idle", 32'({o_busy, o_fifo_level}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
